// File: rtl/sat_pkg.sv
// Shared types and saturation limits for the saturating frame accumulator.
package sat_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StOut
  } state_t;

  // Limits are computed in 64 bits and truncated by the caller to its own width.
  function automatic logic [63:0] sat_umax(input int unsigned width);
    return (64'd1 << width) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_smax(input int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_smin(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/sat_accu_n_if.sv
// Operand and result streams of the saturating accumulator, both valid/ready.
interface sat_accu_n_if #(
  parameter int unsigned WIDTH = 5
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_of;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output out_of
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  out_of
  );

endinterface

// File: rtl/sat_add.sv
// Single-step saturating adder, unsigned or two's-complement.
module sat_add
  import sat_pkg::*;
#(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned SIGNED_MODE = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             of
);

  localparam logic [WIDTH-1:0] UMax = WIDTH'(sat_umax(WIDTH));
  localparam logic [WIDTH-1:0] SMax = WIDTH'(sat_smax(WIDTH));
  localparam logic [WIDTH-1:0] SMin = WIDTH'(sat_smin(WIDTH));

  logic [WIDTH:0] sum;

  if (SIGNED_MODE != 0) begin : g_signed
    always_comb begin
      sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
      // Top two bits disagree only when the true sum left the representable range.
      of  = sum[WIDTH] ^ sum[WIDTH-1];
      if (!of) begin
        s = sum[WIDTH-1:0];
      end else if (sum[WIDTH]) begin
        s = SMin;
      end else begin
        s = SMax;
      end
    end
  end else begin : g_unsigned
    always_comb begin
      sum = {1'b0, a} + {1'b0, b};
      of  = sum[WIDTH];
      s   = of ? UMax : sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/sat_accu_n.sv
// Frame accumulator: sums N_OPS streamed operands with per-step saturation and a
// sticky overflow flag, then presents one registered result per frame.
module sat_accu_n
  import sat_pkg::*;
#(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned N_OPS       = 4,
  parameter int unsigned SIGNED_MODE = 0
) (
  input logic         clk,
  input logic         rst_n,
  input logic         clr,
  sat_accu_n_if.slave bus
);

  localparam int unsigned CntW    = $clog2(N_OPS + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(N_OPS - 1);

  state_t           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [CntW-1:0]  cnt_q;
  logic             of_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_sum_q;
  logic             out_of_q;

  logic [WIDTH-1:0] add_s;
  logic             add_of;
  logic             accept;

  sat_add #(
    .WIDTH       (WIDTH),
    .SIGNED_MODE (SIGNED_MODE)
  ) u_add (
    .a  (acc_q),
    .b  (bus.in_data),
    .s  (add_s),
    .of (add_of)
  );

  assign bus.in_ready  = (state_q != StOut);
  assign accept        = bus.in_valid & bus.in_ready & ~clr;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_of    = out_of_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      of_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_of_q    <= 1'b0;
    end else if (clr) begin
      // Abort wins over any handshake in the same cycle.
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      of_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_of_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StAcc: begin
          if (accept) begin
            acc_q <= add_s;
            of_q  <= of_q | add_of;
            cnt_q <= cnt_q + CntW'(1);
            // acc/cnt are zero in idle, so the same step logic covers the first operand.
            if ((N_OPS == 1) || (state_q == StAcc && cnt_q == LastCnt)) begin
              state_q     <= StOut;
              out_valid_q <= 1'b1;
              out_sum_q   <= add_s;
              out_of_q    <= of_q | add_of;
            end else begin
              state_q <= StAcc;
            end
          end
        end
        StOut: begin
          if (bus.out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            of_q        <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
